ir_err_calc: RTL and testbench
==============================

Name: ir_err_calc

Overview:
- Producer of the `error`/`err_vld` stream consumed by the PID block.
- Sequences four IR emitter/receiver pairs, from pair 0 (inner) to pair 3 (outer).
- For each pair it waits a settle time, then requests two A2D conversions over a start/complete handshake: left sensor, then right sensor.
- Accumulates a weighted left-minus-right difference, saturates it to 16-bit signed, and publishes it with a one-cycle `err_vld` strobe per full sweep.

Parameters:
- SETTLE_CYCLES, 4096: cycles an emitter is on before the first conversion of its pair (minimum 2).
- NUM_PAIRS, 4: sensor pairs per sweep (fixed at 4; weights assume it).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- go  input  1  level: run sweeps continuously while high
- res  input  12  unsigned A2D result, valid when `cnv_cmplt`=1
- cnv_cmplt  input  1  one-cycle pulse: conversion done
- strt_cnv  output  1  one-cycle pulse requesting a conversion
- chnnl  output  3  A2D channel select
- IR_en  output  4  one-hot emitter enable, bit p = pair p
- err_vld  output  1  one-cycle strobe: new `error` value
- error  output  16  signed error, held between strobes

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, pair=0, acc=0, L=R=0, `strt_cnv`=0, `chnnl`=0, `IR_en`=0, `err_vld`=0, `error`=0.
- All outputs are registered.
- States: IDLE, SETTLE, STRT_L, WAIT_L, STRT_R, WAIT_R, ACCUM, DONE.
- IDLE: outputs quiet; `go`=1 -> SETTLE with pair=0, acc=0, settle counter=0.
- SETTLE: `IR_en`=1<<pair; counter increments; at count==SETTLE_CYCLES-1 -> STRT_L.
- STRT_L: `chnnl`=2*pair, `strt_cnv`=1 for exactly this cycle -> WAIT_L.
- WAIT_L: `chnnl` held; on `cnv_cmplt`, capture L=`res` -> STRT_R.
- STRT_R / WAIT_R: same as STRT_L / WAIT_L with `chnnl`=2*pair+1; capture R.
- ACCUM: acc += sign_extend(L-R) <<< pair.
  - acc is 18-bit signed.
  - Weights are 1, 2, 4, 8.
  - Range is ±61425, so acc never overflows.
  - If pair==3 -> DONE; else pair++, counter=0 -> SETTLE.
- `IR_en` stays on from SETTLE through ACCUM of the same pair and switches directly to the next pair's bit.
- DONE:
  - `error` <= sat(acc): >32767 -> 16'h7FFF; <-32768 -> 16'h8000; else acc[15:0].
  - `err_vld` registered high the cycle after DONE, for one cycle only.
  - acc=0, pair=0; `go`=1 -> SETTLE, else -> IDLE with `IR_en`=0.
- Sign convention: positive `error` = left side brighter.
- Sweep latency with `cnv_cmplt` returning k cycles after `strt_cnv`: 4*(SETTLE_CYCLES + 2*(k+1) + 1) + 1 cycles from leaving IDLE to DONE.
- `cnv_cmplt` outside WAIT_L/WAIT_R is ignored, including in the same cycle as `strt_cnv`.
- `go` dropped in SETTLE/STRT_*/ACCUM: next state is IDLE immediately; `IR_en` cleared; no `err_vld`; `error` keeps its old value.
- `go` dropped in WAIT_L/WAIT_R: remain until `cnv_cmplt` (no orphan conversion), then IDLE; no `err_vld`.
- An aborted sweep's partial acc is discarded; the next sweep restarts at pair 0.
- `rst` asserted at any point: immediate return to reset values, including mid-conversion; a later stray `cnv_cmplt` in IDLE is ignored.

Decomposition:
- Package `line_pkg`:
  - state enum `ir_state_t`
  - NUM_PAIRS=4, RES_W=12, ACC_W=18, ERR_W=16
  - ERR_MAX=16'h7FFF, ERR_MIN=16'h8000
- One combinational sub-module `sat_s18_to_s16` (18-bit signed in, 16-bit saturated out).
- Settle counter and FSM stay inline.

Test Plan:
- Common setup: SETTLE_CYCLES=8; A2D model returns `cnv_cmplt` 3 cycles after `strt_cnv` with a per-channel scripted `res`.
- Pair 0 L=100, R=40, all other channels 500 -> single `err_vld`, `error`=60; `chnnl` sequence 0,1,2,3,4,5,6,7; `IR_en` steps 0001,0010,0100,1000.
- Pair 3 L=1000, R=1200, others equal -> `error`=-1600 (16'hF9C0).
- Saturation:
  - All left 4095, all right 0 -> `error`=16'h7FFF.
  - Mirrored -> 16'h8000.
  - All channels 2000 -> `error`=0.
- `go` held high for 3 sweeps -> exactly 3 `err_vld` pulses.
  - Spacing between pulses = 4*(8+2*4+1)+1 = 69 cycles.
  - Each `strt_cnv` is one cycle wide.
- `go` dropped during WAIT_R of pair 1:
  - FSM waits for `cnv_cmplt`, then IDLE with `IR_en`=0.
  - No `err_vld`; `error` keeps its previous value.
- `rst` pulsed mid-SETTLE of pair 2 -> all outputs at reset values in the same cycle; a stray `cnv_cmplt` afterwards causes no change.
- `go` re-raised after reset -> clean sweep from `chnnl`=0.

Source files
------------

// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared types and widths for the IR line-error datapath
package line_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STRT_L,
    WAIT_L,
    STRT_R,
    WAIT_R,
    ACCUM,
    DONE
  } ir_state_t;

  localparam int NUM_PAIRS = 4;
  localparam int PAIR_W    = 2;
  localparam int RES_W     = 12;
  localparam int ACC_W     = 18;
  localparam int ERR_W     = 16;

  localparam logic [ERR_W-1:0] ERR_MAX = 16'h7FFF;
  localparam logic [ERR_W-1:0] ERR_MIN = 16'h8000;

endpackage

// File: rtl/sat_s18_to_s16.sv
// rtl/sat_s18_to_s16.sv - clamp an 18-bit signed value into 16-bit signed range
module sat_s18_to_s16
  import line_pkg::*;
(
  input  logic [ACC_W-1:0] din,
  output logic [ERR_W-1:0] dout
);

  // The value fits when the three top bits agree (bit 15 is a true sign bit).
  always_comb begin
    if (din[ACC_W-1:ERR_W-1] == 3'b000 || din[ACC_W-1:ERR_W-1] == 3'b111) begin
      dout = din[ERR_W-1:0];
    end else if (din[ACC_W-1]) begin
      dout = ERR_MIN;
    end else begin
      dout = ERR_MAX;
    end
  end

endmodule

// File: rtl/ir_err_calc.sv
// rtl/ir_err_calc.sv - sweeps four IR pairs through the A2D and publishes a saturated line error
module ir_err_calc
  import line_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [RES_W-1:0]     res,
  input  logic                 cnv_cmplt,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  output logic [NUM_PAIRS-1:0] IR_en,
  output logic                 err_vld,
  output logic [ERR_W-1:0]     error
);

  localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST = PAIR_W'(NUM_PAIRS - 1);

  ir_state_t             state, nxt_state;
  logic [PAIR_W-1:0]     pair, nxt_pair;
  logic [CNT_W-1:0]      cnt, nxt_cnt;
  logic [ACC_W-1:0]      acc, nxt_acc;
  logic [RES_W-1:0]      l_res, nxt_l;
  logic [RES_W-1:0]      r_res, nxt_r;
  logic                  nxt_strt;
  logic [2:0]            nxt_chnnl;
  logic [NUM_PAIRS-1:0]  nxt_ir;
  logic                  nxt_vld;
  logic [ERR_W-1:0]      nxt_error;
  logic [ERR_W-1:0]      sat_err;
  logic                  abort;
  logic [RES_W:0]        diff;
  logic [ACC_W-1:0]      term;

  sat_s18_to_s16 u_sat (
    .din  (acc),
    .dout (sat_err)
  );

  // Left minus right as a 13-bit two's complement value, sign-extended then weighted by 2^pair.
  assign diff = {1'b0, l_res} - {1'b0, r_res};
  assign term = {{(ACC_W-RES_W-1){diff[RES_W]}}, diff} << pair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pair     <= '0;
      cnt      <= '0;
      acc      <= '0;
      l_res    <= '0;
      r_res    <= '0;
      strt_cnv <= 1'b0;
      chnnl    <= '0;
      IR_en    <= '0;
      err_vld  <= 1'b0;
      error    <= '0;
    end else begin
      state    <= nxt_state;
      pair     <= nxt_pair;
      cnt      <= nxt_cnt;
      acc      <= nxt_acc;
      l_res    <= nxt_l;
      r_res    <= nxt_r;
      strt_cnv <= nxt_strt;
      chnnl    <= nxt_chnnl;
      IR_en    <= nxt_ir;
      err_vld  <= nxt_vld;
      error    <= nxt_error;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_pair  = pair;
    nxt_cnt   = cnt;
    nxt_acc   = acc;
    nxt_l     = l_res;
    nxt_r     = r_res;
    nxt_strt  = 1'b0;
    nxt_chnnl = chnnl;
    nxt_ir    = IR_en;
    nxt_vld   = 1'b0;
    nxt_error = error;
    abort     = 1'b0;

    case (state)
      IDLE: begin
        if (go) begin
          nxt_state = SETTLE;
          nxt_pair  = '0;
          nxt_acc   = '0;
          nxt_cnt   = '0;
          nxt_ir    = 4'b0001;
        end
      end
      SETTLE: begin
        if (!go) begin
          abort = 1'b1;
        end else if (cnt == CNT_LAST) begin
          nxt_state = STRT_L;
          nxt_chnnl = {pair, 1'b0};
          nxt_strt  = 1'b1;
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      STRT_L: begin
        if (!go) abort = 1'b1;
        else     nxt_state = WAIT_L;
      end
      // A conversion in flight is always allowed to finish before abandoning the sweep.
      WAIT_L: begin
        if (cnv_cmplt) begin
          nxt_l = res;
          if (!go) begin
            abort = 1'b1;
          end else begin
            nxt_state = STRT_R;
            nxt_chnnl = {pair, 1'b1};
            nxt_strt  = 1'b1;
          end
        end
      end
      STRT_R: begin
        if (!go) abort = 1'b1;
        else     nxt_state = WAIT_R;
      end
      WAIT_R: begin
        if (cnv_cmplt) begin
          nxt_r = res;
          if (!go) abort = 1'b1;
          else     nxt_state = ACCUM;
        end
      end
      ACCUM: begin
        if (!go) begin
          abort = 1'b1;
        end else begin
          nxt_acc = acc + term;
          if (pair == PAIR_LAST) begin
            nxt_state = DONE;
            nxt_ir    = '0;
          end else begin
            nxt_state = SETTLE;
            nxt_pair  = pair + 1'b1;
            nxt_cnt   = '0;
            nxt_ir    = 4'b0001 << (pair + 1'b1);
          end
        end
      end
      DONE: begin
        nxt_error = sat_err;
        nxt_vld   = 1'b1;
        nxt_acc   = '0;
        nxt_pair  = '0;
        nxt_cnt   = '0;
        if (go) begin
          nxt_state = SETTLE;
          nxt_ir    = 4'b0001;
        end else begin
          nxt_state = IDLE;
          nxt_ir    = '0;
          nxt_chnnl = '0;
        end
      end
      default: nxt_state = IDLE;
    endcase

    if (abort) begin
      nxt_state = IDLE;
      nxt_pair  = '0;
      nxt_acc   = '0;
      nxt_cnt   = '0;
      nxt_ir    = '0;
      nxt_chnnl = '0;
      nxt_strt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_ir_err_calc.sv
// tb/tb_ir_err_calc.sv - directed self-checking bench for ir_err_calc
module tb_ir_err_calc;

  logic        clk;
  logic        rst;
  logic        go;
  logic [11:0] res;
  logic        cnv_cmplt;
  logic        model_cmplt;
  logic        stray_cmplt;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [3:0]  IR_en;
  logic        err_vld;
  logic [15:0] error;

  int checks;
  int failures;

  logic [11:0] ch_res [8];

  logic [2:0]  ch_q [$];
  logic [3:0]  ir_q [$];
  int          vld_t [$];
  int          vld_cnt;
  int          cyc;
  int          run_len;
  int          max_run;
  logic [3:0]  last_ir;

  assign cnv_cmplt = model_cmplt | stray_cmplt;

  ir_err_calc #(.SETTLE_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .res       (res),
    .cnv_cmplt (cnv_cmplt),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .IR_en     (IR_en),
    .err_vld   (err_vld),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A2D model: completion lands three cycles after the start pulse.
  initial begin
    model_cmplt = 1'b0;
    res = '0;
    forever begin
      @(posedge clk);
      if (strt_cnv) begin
        logic [2:0] ch;
        ch = chnnl;
        repeat (2) @(posedge clk);
        #1;
        res = ch_res[ch];
        model_cmplt = 1'b1;
        @(posedge clk);
        #1;
        model_cmplt = 1'b0;
      end
    end
  end

  initial begin
    vld_cnt = 0;
    cyc = 0;
    run_len = 0;
    max_run = 0;
    last_ir = '0;
    forever begin
      @(negedge clk);
      if (strt_cnv) begin
        ch_q.push_back(chnnl);
        run_len++;
      end else begin
        run_len = 0;
      end
      if (run_len > max_run) max_run = run_len;
      if (IR_en !== last_ir) begin
        ir_q.push_back(IR_en);
        last_ir = IR_en;
      end
      if (err_vld) begin
        vld_cnt++;
        vld_t.push_back(cyc);
      end
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_vld(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (err_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_lr(input logic [11:0] l, input logic [11:0] r);
    for (int p = 0; p < 4; p++) begin
      ch_res[2*p]   = l;
      ch_res[2*p+1] = r;
    end
  endtask

  task automatic sweep(input string tag, input logic [15:0] exp_err);
    bit ok;
    int vb;
    vb = vld_cnt;
    go = 1'b1;
    wait_vld(ok);
    go = 1'b0;
    check({tag, "_vld_seen"}, 32'(ok), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    repeat (3) @(negedge clk);
    check({tag, "_vld_count"}, 32'(vld_cnt - vb), 32'd1);
  endtask

  initial begin
    bit ok;
    int cb, ib, vb;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    go = 1'b0;
    stray_cmplt = 1'b0;
    set_lr(12'd500, 12'd500);

    @(negedge clk);
    check("rst_strt_cnv", 32'(strt_cnv), 32'd0);
    check("rst_chnnl", 32'(chnnl), 32'd0);
    check("rst_ir_en", 32'(IR_en), 32'd0);
    check("rst_err_vld", 32'(err_vld), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Inner pair only differs: 100-40 = 60.
    set_lr(12'd500, 12'd500);
    ch_res[0] = 12'd100;
    ch_res[1] = 12'd40;
    cb = ch_q.size();
    ib = ir_q.size();
    sweep("pair0", 16'd60);
    for (int i = 0; i < 8; i++) check("chnnl_seq", 32'(ch_q[cb+i]), 32'(i));
    for (int i = 0; i < 4; i++) check("ir_en_step", 32'(ir_q[ib+i]), 32'(1 << i));

    // Outer pair weighted by 8: (1000-1200)*8 = -1600.
    set_lr(12'd500, 12'd500);
    ch_res[6] = 12'd1000;
    ch_res[7] = 12'd1200;
    sweep("pair3", 16'hF9C0);

    set_lr(12'd4095, 12'd0);
    sweep("sat_pos", 16'h7FFF);
    set_lr(12'd0, 12'd4095);
    sweep("sat_neg", 16'h8000);
    set_lr(12'd2000, 12'd2000);
    sweep("balanced", 16'h0000);

    // Three back-to-back sweeps with go held high.
    set_lr(12'd500, 12'd500);
    ch_res[0] = 12'd100;
    ch_res[1] = 12'd40;
    vb = vld_cnt;
    ib = vld_t.size();
    go = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_vld(ok);
      check("multi_vld_seen", 32'(ok), 32'd1);
      check("multi_error", 32'(error), 32'd60);
    end
    go = 1'b0;
    repeat (3) @(negedge clk);
    check("multi_vld_count", 32'(vld_cnt - vb), 32'd3);
    check("multi_spacing_1", 32'(vld_t[ib+1] - vld_t[ib]), 32'd69);
    check("multi_spacing_2", 32'(vld_t[ib+2] - vld_t[ib+1]), 32'd69);
    check("strt_cnv_width", 32'(max_run), 32'd1);

    // Drop go while the right conversion of pair 1 is outstanding.
    vb = vld_cnt;
    go = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (strt_cnv && chnnl == 3'd3) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_reach_strt_r1", 32'(ok), 32'd1);
    @(negedge clk);
    go = 1'b0;
    cb = ch_q.size();
    @(negedge clk);
    check("abort_wait_ir_en", 32'(IR_en), 32'b0010);
    repeat (3) @(negedge clk);
    check("abort_idle_ir_en", 32'(IR_en), 32'd0);
    check("abort_no_new_strt", 32'(ch_q.size() - cb), 32'd0);
    check("abort_no_vld", 32'(vld_cnt - vb), 32'd0);
    check("abort_error_held", 32'(error), 32'd60);

    // Asynchronous reset in the middle of pair 2 settle.
    go = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (IR_en == 4'b0100) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_reach_pair2", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_strt_cnv", 32'(strt_cnv), 32'd0);
    check("midrst_chnnl", 32'(chnnl), 32'd0);
    check("midrst_ir_en", 32'(IR_en), 32'd0);
    check("midrst_err_vld", 32'(err_vld), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    vb = vld_cnt;
    cb = ch_q.size();
    @(negedge clk);
    stray_cmplt = 1'b1;
    @(negedge clk);
    stray_cmplt = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ir_en", 32'(IR_en), 32'd0);
    check("stray_no_strt", 32'(ch_q.size() - cb), 32'd0);
    check("stray_no_vld", 32'(vld_cnt - vb), 32'd0);
    check("stray_error", 32'(error), 32'd0);

    // Clean restart from pair 0.
    cb = ch_q.size();
    sweep("restart", 16'd60);
    check("restart_first_chnnl", 32'(ch_q[cb]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
